ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch front end. Reads the word-addressed program counter stream
//   (next = pc + 1, redirect via `PC_* codes from codes.v), issues instruction-
//   memory reads, buffers in-order responses and hands {instr, pc} to decode.
//  Sits between the PC/redirect logic and decode. Redirects flush wrong-path
//   instructions, both buffered and in flight.
// PARAMETERS
//  DEPTH     4   max requests in flight plus buffered entries; power of 2, >=2
//  RESET_PC  0   fetch address loaded on reset
// PORTS
//  clock           in   1   clock, rising edge
//  reset           in   1   reset, synchronous, active-high
//  redir_sel       in   2   `PC_PLUS_4 = sequential; `PC_JAL/`PC_JALR/`PC_BRANCH = redirect
//  jal             in   32  redirect target when redir_sel == `PC_JAL
//  jalr            in   32  redirect target when redir_sel == `PC_JALR
//  branch          in   32  redirect target when redir_sel == `PC_BRANCH
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address of request
//  imem_rsp_valid  in   1   read data valid; in order, >=1 cycle after acceptance
//  imem_rsp_data   in   32  read data
//  instr_valid     out  1   instr/instr_pc valid to decode
//  instr_ready     in   1   decode accepts
//  instr           out  32  instruction word
//  instr_pc        out  32  word address of instr
// BEHAVIOUR
//  State: fetch_addr, rsp_pc (32b), inflight, drop_cnt (0..DEPTH), FIFO of
//   DEPTH x {instr, pc}.
//  Reset: fetch_addr = rsp_pc = RESET_PC; inflight = drop_cnt = 0; FIFO empty.
//   imem_req_valid = 0 and instr_valid = 0 in reset cycle. Reset mid-operation
//   discards everything; memory is reset in the same cycle.
//  Issue: imem_req_valid = !redirect && (inflight + drop_cnt + fifo_count < DEPTH);
//   independent of imem_req_ready. imem_req_addr = fetch_addr.
//   On accept: fetch_addr += 1, mod 2^32 (32'hFFFFFFFF -> 0); inflight += 1.
//  Response: inflight -= 1. If drop_cnt > 0: discard, drop_cnt -= 1.
//   Else push {data, rsp_pc} into FIFO; rsp_pc += 1 (mod 2^32).
//   The credit rule guarantees no push into a full FIFO.
//  Output: instr_valid = FIFO non-empty; head drives instr/instr_pc.
//   Pop on instr_valid && instr_ready. Valid/data hold until accepted.
//  Redirect (redir_sel != `PC_PLUS_4), one cycle:
//   - no request issued that cycle
//   - at the edge: fetch_addr = rsp_pc = selected target; FIFO cleared
//   - drop_cnt += inflight, minus 1 if a response arrives that cycle
//     (that response is itself discarded)
//   - an instr handshake in the redirect cycle completes normally
//   - first new request issues the next cycle if credit allows
//  Back-to-back redirects: latest wins; drop counts accumulate.
//  Latency, no bypass: req accept at T, rsp at T+L -> instr_valid at T+L+1.
// CONFIGURATION
//  IFETCH_BYPASS_EN defined: FIFO empty, non-dropped rsp_valid, no redirect:
//   instr_valid = 1 the same cycle, instr = imem_rsp_data, instr_pc = rsp_pc.
//   If instr_ready, no FIFO write; else the entry is pushed as normal.
//  Undefined: no combinational rsp->instr path; behaviour as above.
// TESTING
//  1. Reset, ready = 1, 1-cycle memory: addrs 0,1,2,3... issued;
//     instr_pc 0,1,2... one per cycle after fill; mem[k] = k+100 -> instr = k+100.
//  2. instr_ready = 0, DEPTH = 4: exactly 4 requests accepted, then
//     imem_req_valid = 0; FIFO holds pc 0..3. Ready = 1 drains in order
//     and fetch resumes at addr 4.
//  3. 2 requests in flight (addr 8, 9), `PC_BRANCH, branch = 0x40:
//     both responses discarded; next request addr 0x40; first instr_pc = 0x40.
//  4. Redirect cycle with rsp_valid = 1 and instr handshake:
//     current head accepted, the arriving response dropped, FIFO empty after;
//     `PC_JALR, jalr = 0x10 -> next addr 0x10.
//  5. RESET_PC = 32'hFFFFFFFE: addrs FFFFFFFE, FFFFFFFF, 0, 1;
//     instr_pc follows the same wrap.
//  6. IFETCH_BYPASS_EN, FIFO empty, ready = 1: rsp at cycle T gives
//     instr_valid at T; without the macro, at T+1.

Source files
------------

// File: rtl/ifetch.sv
// ifetch: instruction fetch front end with credit-limited issue, in-order response FIFO and redirect flush.
// Optional IFETCH_BYPASS_EN hands a response straight to decode when the FIFO is empty.
`ifndef PC_PLUS_4
`define PC_PLUS_4 2'd0
`endif
`ifndef PC_JAL
`define PC_JAL 2'd1
`endif
`ifndef PC_JALR
`define PC_JALR 2'd2
`endif
`ifndef PC_BRANCH
`define PC_BRANCH 2'd3
`endif

module ifetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] jal,
  input  logic [31:0] jalr,
  input  logic [31:0] branch,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_addr;
  logic [31:0]   rsp_pc;
  logic [31:0]   target;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];
  logic [CW+1:0] used;
  logic          redirect;
  logic          fifo_empty;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_drop;
  logic          rsp_keep;
  logic          bypass;
  logic          push;
  logic          pop;

  always_comb begin
    target = fetch_addr;
    case (redir_sel)
      `PC_JAL:    target = jal;
      `PC_JALR:   target = jalr;
      `PC_BRANCH: target = branch;
      default:    target = fetch_addr;
    endcase
  end

  // inflight counts only live requests; requests already marked for discard sit in drop_cnt
  assign used           = {2'b00, inflight} + {2'b00, drop_cnt} + {2'b00, fifo_count};
  assign redirect       = (redir_sel != `PC_PLUS_4);
  assign imem_req_valid = !reset && !redirect && (used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_addr;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_live       = imem_rsp_valid && (drop_cnt == '0);
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_keep       = !reset && rsp_live && !redirect;
  assign fifo_empty     = (fifo_count == '0);

`ifdef IFETCH_BYPASS_EN
  assign bypass      = fifo_empty && rsp_keep;
  assign instr_valid = !reset && (!fifo_empty || bypass);
  assign instr       = fifo_empty ? imem_rsp_data : fifo_instr[rd_ptr];
  assign instr_pc    = fifo_empty ? rsp_pc : fifo_pc[rd_ptr];
`else
  assign bypass      = 1'b0;
  assign instr_valid = !reset && !fifo_empty;
  assign instr       = fifo_instr[rd_ptr];
  assign instr_pc    = fifo_pc[rd_ptr];
`endif

  assign pop  = !fifo_empty && instr_valid && instr_ready;
  assign push = rsp_keep && !(bypass && instr_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_addr <= RESET_PC;
      rsp_pc     <= RESET_PC;
      inflight   <= '0;
      drop_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect) begin
      // every outstanding request becomes wrong-path; a response arriving now retires one of them
      fetch_addr <= target;
      rsp_pc     <= target;
      inflight   <= '0;
      drop_cnt   <= drop_cnt + inflight - CW'(imem_rsp_valid);
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (req_fire) fetch_addr <= fetch_addr + 32'd1;
      if (rsp_keep) rsp_pc <= rsp_pc + 32'd1;
      inflight <= inflight + CW'(req_fire) - CW'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]    <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed bench for ifetch with an in-order memory model and a second instance for RESET_PC wrap.
`ifndef PC_PLUS_4
`define PC_PLUS_4 2'd0
`endif
`ifndef PC_JAL
`define PC_JAL 2'd1
`endif
`ifndef PC_JALR
`define PC_JALR 2'd2
`endif
`ifndef PC_BRANCH
`define PC_BRANCH 2'd3
`endif

module tb_ifetch;

`ifdef IFETCH_BYPASS_EN
  localparam int FILL = 1;
`else
  localparam int FILL = 2;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  redir_sel;
  logic [31:0] jal, jalr, branch;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;

  logic [1:0]  w_redir;
  logic        w_req_valid, w_req_ready;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid, w_instr_ready;
  logic [31:0] w_instr, w_instr_pc;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat = 1;
  int          accepts = 0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  always #5 clock = ~clock;

  ifetch #(.DEPTH(4), .RESET_PC(32'd0)) dut (
    .clock(clock), .reset(reset), .redir_sel(redir_sel),
    .jal(jal), .jalr(jalr), .branch(branch),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  ifetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE)) u_wrap (
    .clock(clock), .reset(reset), .redir_sel(w_redir),
    .jal(jal), .jalr(jalr), .branch(branch),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr), .instr_pc(w_instr_pc)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory answers in order, lat cycles after acceptance, with data = addr + 100
  task automatic applyStimulus();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!reset && q_addr.size() > 0 && q_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = q_addr[0] + 32'd100;
      q_addr.delete(0);
      q_due.delete(0);
    end
    #1;
  endtask

  task automatic advance();
    if (!reset && imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
      accepts++;
    end
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic doReset();
    reset = 1'b1;
    redir_sel = `PC_PLUS_4;
    w_redir = `PC_PLUS_4;
    jal = '0; jalr = '0; branch = '0;
    imem_req_ready = 1'b1;
    instr_ready = 1'b1;
    w_req_ready = 1'b1;
    w_rsp_valid = 1'b0;
    w_rsp_data = '0;
    w_instr_ready = 1'b0;
    lat = 1;
    q_addr.delete();
    q_due.delete();
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      checkOutput("reset_req_valid", imem_req_valid, 32'd0);
      checkOutput("reset_instr_valid", instr_valid, 32'd0);
      advance();
    end
    reset = 1'b0;
  endtask

  initial begin
    logic        found;
    logic [31:0] wexp;
    int          n;

    // streaming fetch with a 1-cycle memory
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      checkOutput("t1_req_valid", imem_req_valid, 32'd1);
      checkOutput("t1_req_addr", imem_req_addr, 32'(i));
      if (i >= FILL) begin
        checkOutput("t1_instr_valid", instr_valid, 32'd1);
        checkOutput("t1_instr_pc", instr_pc, 32'(i - FILL));
        checkOutput("t1_instr", instr, 32'(i - FILL + 100));
      end else begin
        checkOutput("t1_instr_idle", instr_valid, 32'd0);
      end
      advance();
    end

    // decode stalled: credit stops issue at DEPTH, then drains in order
    doReset();
    instr_ready = 1'b0;
    accepts = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      advance();
    end
    applyStimulus();
    checkOutput("t2_accepts", 32'(accepts), 32'd4);
    checkOutput("t2_req_stalled", imem_req_valid, 32'd0);
    checkOutput("t2_head_valid", instr_valid, 32'd1);
    checkOutput("t2_head_pc", instr_pc, 32'd0);
    advance();
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus();
      checkOutput("t2_drain_valid", instr_valid, 32'd1);
      checkOutput("t2_drain_pc", instr_pc, 32'(k));
      checkOutput("t2_drain_instr", instr, 32'(k + 100));
      if (k == 0) checkOutput("t2_full_no_req", imem_req_valid, 32'd0);
      if (k == 1) begin
        checkOutput("t2_resume_valid", imem_req_valid, 32'd1);
        checkOutput("t2_resume_addr", imem_req_addr, 32'd4);
      end
      advance();
    end

    // branch redirect with two requests in flight
    doReset();
    redir_sel = `PC_JAL;
    jal = 32'd8;
    applyStimulus();
    checkOutput("t3_jal_no_req", imem_req_valid, 32'd0);
    advance();
    redir_sel = `PC_PLUS_4;
    lat = 3;
    applyStimulus();
    checkOutput("t3_req8", imem_req_addr, 32'd8);
    checkOutput("t3_req8_valid", imem_req_valid, 32'd1);
    advance();
    applyStimulus();
    checkOutput("t3_req9", imem_req_addr, 32'd9);
    advance();
    redir_sel = `PC_BRANCH;
    branch = 32'h40;
    applyStimulus();
    checkOutput("t3_redir_no_req", imem_req_valid, 32'd0);
    advance();
    redir_sel = `PC_PLUS_4;
    applyStimulus();
    checkOutput("t3_new_req_valid", imem_req_valid, 32'd1);
    checkOutput("t3_new_req_addr", imem_req_addr, 32'h40);
    advance();
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      applyStimulus();
      if (instr_valid) begin
        checkOutput("t3_first_pc", instr_pc, 32'h40);
        checkOutput("t3_first_instr", instr, 32'h40 + 32'd100);
        found = 1'b1;
      end
      advance();
    end
    checkOutput("t3_first_seen", 32'(found), 32'd1);

    // redirect coinciding with a response and a decode handshake
    doReset();
    instr_ready = 1'b0;
    applyStimulus();
    advance();
    applyStimulus();
    advance();
    redir_sel = `PC_JALR;
    jalr = 32'h10;
    instr_ready = 1'b1;
    applyStimulus();
    checkOutput("t4_head_valid", instr_valid, 32'd1);
    checkOutput("t4_head_pc", instr_pc, 32'd0);
    checkOutput("t4_head_instr", instr, 32'd100);
    checkOutput("t4_redir_no_req", imem_req_valid, 32'd0);
    advance();
    redir_sel = `PC_PLUS_4;
    applyStimulus();
    checkOutput("t4_fifo_empty", instr_valid, 32'd0);
    checkOutput("t4_req_valid", imem_req_valid, 32'd1);
    checkOutput("t4_req_addr", imem_req_addr, 32'h10);
    advance();
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      applyStimulus();
      if (instr_valid) begin
        checkOutput("t4_first_pc", instr_pc, 32'h10);
        checkOutput("t4_first_instr", instr, 32'h10 + 32'd100);
        found = 1'b1;
      end
      advance();
    end
    checkOutput("t4_first_seen", 32'(found), 32'd1);

    // address and pc wrap from RESET_PC = FFFFFFFE
    doReset();
    wexp = 32'hFFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      if (i < 4) begin
        checkOutput("t5_req_valid", w_req_valid, 32'd1);
        checkOutput("t5_req_addr", w_req_addr, wexp);
        wexp = wexp + 32'd1;
      end else begin
        checkOutput("t5_credit_stall", w_req_valid, 32'd0);
      end
      advance();
    end
    wexp = 32'hFFFF_FFFE;
    n = 0;
    w_instr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w_rsp_valid = (k < 4);
      w_rsp_data  = 32'hA0 + 32'(k);
      applyStimulus();
      if (w_instr_valid) begin
        checkOutput("t5_instr_pc", w_instr_pc, wexp);
        checkOutput("t5_instr", w_instr, 32'hA0 + 32'(n));
        wexp = wexp + 32'd1;
        n++;
      end
      advance();
    end
    checkOutput("t5_instr_count", 32'(n), 32'd4);

    // bypass timing: response at T is visible at T with the bypass, T+1 without
    doReset();
    applyStimulus();
    advance();
    applyStimulus();
    checkOutput("t6_rsp_cycle_valid", instr_valid, (FILL == 1) ? 32'd1 : 32'd0);
    advance();
    applyStimulus();
    checkOutput("t6_next_cycle_valid", instr_valid, 32'd1);
    checkOutput("t6_next_cycle_pc", instr_pc, (FILL == 1) ? 32'd1 : 32'd0);
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
